// File: rtl/viterbi_pkg.sv
// Shared rate-1/2, K=3 convolutional code definitions used by the encoder feeder and the decoder.
package viterbi_pkg;

    localparam int unsigned K        = 3;
    localparam int unsigned RATE_NUM = 1;
    localparam int unsigned RATE_DEN = 2;

    localparam logic [K-1:0] G0_DEFAULT = 3'b111;
    localparam logic [K-1:0] G1_DEFAULT = 3'b101;

    typedef logic [1:0]   fsm_state_t;
    typedef logic [K-2:0] enc_state_t;

    localparam fsm_state_t StIdle = 2'd0;
    localparam fsm_state_t StEnc  = 2'd1;
    localparam fsm_state_t StSend = 2'd2;

    function automatic logic tap_parity(input logic [K-1:0] g, input logic [K-1:0] r);
        return ^(g & r);
    endfunction

endpackage

// File: rtl/conv_enc_feeder_if.sv
// Byte-in / codeword-out bundle of conv_enc_feeder.
// Adds err_mask_i when VITERBI_ERR_INJECT_EN is defined.
interface conv_enc_feeder_if;

    logic        byte_valid_i;
    logic [7:0]  byte_i;
    logic        byte_ready_o;
    logic        clear_i;
    logic        busy_i;
    logic        dvalid_o;
    logic [15:0] data_o;

`ifdef VITERBI_ERR_INJECT_EN
    logic [15:0] err_mask_i;

    modport master (
        output byte_valid_i, byte_i, clear_i, busy_i, err_mask_i,
        input  byte_ready_o, dvalid_o, data_o
    );
    modport slave (
        input  byte_valid_i, byte_i, clear_i, busy_i, err_mask_i,
        output byte_ready_o, dvalid_o, data_o
    );
`else
    modport master (
        output byte_valid_i, byte_i, clear_i, busy_i,
        input  byte_ready_o, dvalid_o, data_o
    );
    modport slave (
        input  byte_valid_i, byte_i, clear_i, busy_i,
        output byte_ready_o, dvalid_o, data_o
    );
`endif

endinterface

// File: rtl/conv_enc_step.sv
// One combinational step of the K=3 convolutional encoder: {u, s1, s0} -> {out0, out1, next state}.
module conv_enc_step
    import viterbi_pkg::*;
#(
    parameter logic [K-1:0] G0 = G0_DEFAULT,
    parameter logic [K-1:0] G1 = G1_DEFAULT
) (
    input  logic       u_i,
    input  enc_state_t state_i,
    output logic       out0_o,
    output logic       out1_o,
    output enc_state_t state_next_o
);

    logic [K-1:0] taps;

    always_comb begin
        taps         = {u_i, state_i};
        out0_o       = tap_parity(G0, taps);
        out1_o       = tap_parity(G1, taps);
        state_next_o = {u_i, state_i[1]};
    end

endmodule

// File: rtl/conv_enc_feeder.sv
// Accepts information bytes, encodes them MSB first at one bit per cycle and hands each 16-bit
// codeword to a decoder that may stall. Optional error injection under VITERBI_ERR_INJECT_EN.
module conv_enc_feeder
    import viterbi_pkg::*;
#(
    parameter logic [K-1:0] G0 = G0_DEFAULT,
    parameter logic [K-1:0] G1 = G1_DEFAULT
) (
    input logic               clk,
    input logic               rst_n,
    conv_enc_feeder_if.slave  bus
);

    localparam int unsigned WordW = 8 * RATE_DEN / RATE_NUM;

    fsm_state_t       state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic [2:0]       cnt_q, cnt_d;
    enc_state_t       enc_q, enc_d;
    logic [WordW-3:0] shift_q, shift_d;
    logic [WordW-1:0] data_q, data_d;

    logic       out0, out1;
    enc_state_t enc_next;

    conv_enc_step #(
        .G0 (G0),
        .G1 (G1)
    ) u_step (
        .u_i          (byte_q[7]),
        .state_i      (enc_q),
        .out0_o       (out0),
        .out1_o       (out1),
        .state_next_o (enc_next)
    );

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        cnt_d   = cnt_q;
        enc_d   = enc_q;
        shift_d = shift_q;
        data_d  = data_q;
        case (state_q)
            StIdle: begin
                // Clear only resets the trellis; a byte taken in the same cycle starts from 00.
                if (bus.clear_i) begin
                    enc_d = '0;
                end
                if (bus.byte_valid_i) begin
                    byte_d  = bus.byte_i;
                    cnt_d   = 3'd0;
                    state_d = StEnc;
                end
            end
            StEnc: begin
                byte_d  = {byte_q[6:0], 1'b0};
                enc_d   = enc_next;
                shift_d = {shift_q[WordW-5:0], out0, out1};
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    data_d  = {shift_q, out0, out1};
                    state_d = StSend;
                end
            end
            StSend: begin
                if (!bus.busy_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            byte_q  <= '0;
            cnt_q   <= '0;
            enc_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            cnt_q   <= cnt_d;
            enc_q   <= enc_d;
            shift_q <= shift_d;
            data_q  <= data_d;
        end
    end

    // The word is complete on entry to SEND, so the pulse is issued in SEND itself.
    assign bus.byte_ready_o = (state_q == StIdle);
    assign bus.dvalid_o     = (state_q == StSend) && !bus.busy_i;

`ifdef VITERBI_ERR_INJECT_EN
    assign bus.data_o = data_q ^ ((state_q == StSend) ? bus.err_mask_i : '0);
`else
    assign bus.data_o = data_q;
`endif

endmodule

// File: tb/tb_conv_enc_feeder.sv
// Scoreboard bench for conv_enc_feeder: expected words queued at accept, checked on each dvalid_o.
module tb_conv_enc_feeder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    conv_enc_feeder_if bus ();

    conv_enc_feeder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int pulses = 0;
    int cyc = 0;

    logic [15:0] exp_q[$];
    int          lat_q[$];
    int          acc_q[$];
    logic [1:0]  m_st;

    logic [15:0] mon_exp;
    int          mon_lat;
    int          mon_acc;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference encoder: returns {word, next state} for byte b starting from state st = {s1,s0}.
    function automatic logic [17:0] model_enc(input logic [7:0] b, input logic [1:0] st);
        logic [15:0] w;
        logic [2:0]  r;
        logic [1:0]  s;
        w = '0;
        s = st;
        for (int i = 7; i >= 0; i--) begin
            r = {b[i], s};
            w = {w[13:0], ^(r & 3'b111), ^(r & 3'b101)};
            s = {b[i], s[1]};
        end
        return {w, s};
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.byte_valid_i && bus.byte_ready_o) acc_q.push_back(cyc);
        if (rst_n && bus.dvalid_o) begin
            pulses++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: data_o=%h with no word expected", bus.data_o);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_lat = lat_q.pop_front();
                mon_acc = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
                if (bus.data_o !== mon_exp) begin
                    bad++;
                    $display("FAIL word: data_o=%h expected=%h", bus.data_o, mon_exp);
                end
                if (mon_lat >= 0) begin
                    total++;
                    if (cyc - mon_acc != mon_lat) begin
                        bad++;
                        $display("FAIL latency: got=%0d expected=%0d", cyc - mon_acc, mon_lat);
                    end
                end
            end
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.byte_valid_i = 1'b0;
        bus.byte_i = 8'h00;
        bus.clear_i = 1'b0;
        bus.busy_i = 1'b0;
        exp_q.delete();
        lat_q.delete();
        acc_q.delete();
        m_st = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic clr, input logic [15:0] exp,
                             input int lat);
        exp_q.push_back(exp);
        lat_q.push_back(lat);
        bus.byte_i = b;
        bus.clear_i = clr;
        bus.byte_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.byte_valid_i = 1'b0;
        bus.clear_i = 1'b0;
    endtask

    task automatic wait_pulse(input int max_cycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(negedge clk);
            if (bus.dvalid_o) seen = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        total++;
        if (bus.dvalid_o !== 1'b0) begin
            bad++; $display("FAIL reset_dvalid: got=%b expected=0", bus.dvalid_o);
        end
        apply_reset();
        total++;
        if (bus.byte_ready_o !== 1'b1) begin
            bad++; $display("FAIL reset_ready: got=%b expected=1", bus.byte_ready_o);
        end
        total++;
        if (bus.data_o !== 16'h0000) begin
            bad++; $display("FAIL reset_data: got=%h expected=0000", bus.data_o);
        end
        total++;
        if (bus.dvalid_o !== 1'b0) begin
            bad++; $display("FAIL reset_dvalid_after: got=%b expected=0", bus.dvalid_o);
        end
    endtask

    task automatic test_zero_byte();
        bit seen;
        apply_reset();
        send_byte(8'h00, 1'b0, 16'h0000, 9);
        wait_pulse(20, seen);
        total++;
        if (!seen) begin bad++; $display("FAIL zero_byte_timeout: pulse=0 expected=1"); end
    endtask

    task automatic test_msb_byte();
        bit seen;
        apply_reset();
        send_byte(8'h80, 1'b0, 16'hEC00, 9);
        wait_pulse(20, seen);
        total++;
        if (!seen) begin bad++; $display("FAIL msb_timeout: pulse=0 expected=1"); end
        // A zero byte after 0x80 yields all zeros only if the trellis returned to 00.
        send_byte(8'h00, 1'b0, 16'h0000, 9);
        wait_pulse(20, seen);
        total++;
        if (!seen) begin bad++; $display("FAIL msb_state_timeout: pulse=0 expected=1"); end
    endtask

    task automatic test_all_ones();
        bit seen;
        apply_reset();
        send_byte(8'hFF, 1'b0, 16'hDAAA, 9);
        wait_pulse(20, seen);
        send_byte(8'h00, 1'b0, 16'h7000, 9);
        wait_pulse(20, seen);
        total++;
        if (!seen) begin bad++; $display("FAIL all_ones_timeout: pulse=0 expected=1"); end
    endtask

    task automatic test_clear();
        bit seen;
        apply_reset();
        send_byte(8'hFF, 1'b0, 16'hDAAA, 9);
        wait_pulse(20, seen);
        send_byte(8'h00, 1'b1, 16'h0000, 9);
        wait_pulse(20, seen);
        total++;
        if (!seen) begin bad++; $display("FAIL clear_timeout: pulse=0 expected=1"); end
    endtask

    task automatic test_busy();
        bit seen;
        int early;
        apply_reset();
        bus.busy_i = 1'b1;
        send_byte(8'h80, 1'b0, 16'hEC00, -1);
        early = 0;
        repeat (28) begin
            @(negedge clk);
            if (bus.dvalid_o) early++;
        end
        total++;
        if (early != 0) begin bad++; $display("FAIL busy_pulse: pulses=%0d expected=0", early); end
        total++;
        if (bus.byte_ready_o !== 1'b0) begin
            bad++; $display("FAIL busy_ready: got=%b expected=0", bus.byte_ready_o);
        end
        @(posedge clk);
        #1 bus.busy_i = 1'b0;
        wait_pulse(2, seen);
        total++;
        if (!seen) begin bad++; $display("FAIL busy_release: pulse=0 expected=1"); end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_enc();
        int p0;
        bus.byte_i = 8'hFF;
        bus.byte_valid_i = 1'b1;
        @(posedge clk);
        #1 bus.byte_valid_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        p0 = pulses;
        apply_reset();
        total++;
        if (bus.byte_ready_o !== 1'b1) begin
            bad++; $display("FAIL midenc_ready: got=%b expected=1", bus.byte_ready_o);
        end
        repeat (15) @(posedge clk);
        #1;
        total++;
        if (pulses != p0) begin
            bad++; $display("FAIL midenc_pulse: pulses=%0d expected=%0d", pulses, p0);
        end
    endtask

    task automatic test_back_to_back();
        bit seen;
        logic [7:0]  b;
        logic        clr;
        logic [17:0] r;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom_range(0, 255));
            clr = ($urandom_range(0, 3) == 0);
            if (clr) m_st = 2'b00;
            r = model_enc(b, m_st);
            m_st = r[1:0];
            send_byte(b, clr, r[17:2], 9);
            wait_pulse(20, seen);
            total++;
            if (!seen) begin bad++; $display("FAIL stream_timeout: byte=%h pulse=0", b); end
        end
    endtask

`ifdef VITERBI_ERR_INJECT_EN
    task automatic test_err_inject();
        bit seen;
        apply_reset();
        bus.err_mask_i = 16'h0001;
        send_byte(8'h80, 1'b0, 16'hEC01, 9);
        wait_pulse(20, seen);
        bus.err_mask_i = 16'h0000;
        total++;
        if (!seen) begin bad++; $display("FAIL err_inject_timeout: pulse=0 expected=1"); end
    endtask
`endif

    initial begin
`ifdef VITERBI_ERR_INJECT_EN
        bus.err_mask_i = 16'h0000;
`endif
        bus.byte_valid_i = 1'b0;
        bus.byte_i = 8'h00;
        bus.clear_i = 1'b0;
        bus.busy_i = 1'b0;
        test_reset();
        test_zero_byte();
        test_msb_byte();
        test_all_ones();
        test_clear();
        test_busy();
        test_reset_mid_enc();
        test_back_to_back();
`ifdef VITERBI_ERR_INJECT_EN
        test_err_inject();
`endif
        repeat (3) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL leftover_words: pending=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/conv_enc_feeder.md
CONV_ENC_FEEDER -- requirements
Module: conv_enc_feeder

Interface
REQ-001 SHALL have parameter G0, default 3'b111, generator polynomial for output bit 0 (taps: u, s1, s0).
REQ-002 SHALL have parameter G1, default 3'b101, generator polynomial for output bit 1.
REQ-003 SHALL have port clk, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port byte_valid_i, input, 1 bit, upstream byte offer.
REQ-006 SHALL have port byte_i, input, 8 bits, information byte; bit 7 is encoded first.
REQ-007 SHALL have port byte_ready_o, output, 1 bit, block can accept a byte this cycle.
REQ-008 SHALL have port clear_i, input, 1 bit, synchronous encoder-state clear.
REQ-009 SHALL have port busy_i, input, 1 bit, downstream decoder busy; no word is issued while it is high.
REQ-010 SHALL have port dvalid_o, output, 1 bit, one-cycle pulse qualifying data_o.
REQ-011 SHALL have port data_o, output, 16 bits, encoded word; pair k, for k = 0..7 with k=0 from byte bit 7, sits at [15-2k:14-2k] as {G0 out, G1 out}.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, ENC, SEND.
REQ-013 SHALL drive byte_ready_o high only in IDLE; a byte is accepted when byte_valid_i and byte_ready_o are both high.
REQ-014 SHALL, on accept, latch byte_i, clear a 3-bit bit counter to 0, and enter ENC.
REQ-015 SHALL, in ENC, encode one bit per cycle, MSB first: out0 = parity(G0 & {u,s1,s0}), out1 = parity(G1 & {u,s1,s0}); then s0<=s1 and s1<=u.
REQ-016 SHALL leave ENC for SEND after the 8th bit, when the counter equals 7.
REQ-017 SHALL, in SEND with busy_i low, register data_o, pulse dvalid_o high for exactly one cycle, and return to IDLE.
REQ-018 SHALL, in SEND with busy_i high, hold the state and the word indefinitely; dvalid_o stays low.
REQ-019 SHALL give a minimum latency of 9 cycles from the accept cycle to the dvalid_o high cycle.
REQ-020 SHALL hold data_o stable between pulses; its value is don't-care while dvalid_o is low.
REQ-021 SHALL carry encoder state {s1,s0} across bytes, so the stream is continuous.
REQ-022 SHALL, when clear_i is high in IDLE, zero {s1,s0}; if a byte is accepted in the same cycle, that byte encodes from state 00.
REQ-023 SHALL ignore clear_i in ENC and SEND.
REQ-024 SHALL ignore byte_valid_i outside IDLE, with no drop flag; the upstream must hold the offer.

Reset
REQ-025 SHALL, on rst_n low, asynchronously force FSM=IDLE, {s1,s0}=00, counter=0, dvalid_o=0, data_o=16'h0000, and byte_ready_o=1 after release.
REQ-026 SHALL, on reset asserted mid-ENC or mid-SEND, discard the in-flight byte; no dvalid_o pulse follows.

Configuration
REQ-027 SHALL, with macro VITERBI_ERR_INJECT_EN defined, add input err_mask_i[15:0], sampled in SEND and XORed onto data_o for channel-error testing.
REQ-028 SHALL, without VITERBI_ERR_INJECT_EN, omit err_mask_i and output the pure codeword.

Structure
REQ-029 SHALL take from shared package viterbi_pkg: the generator defaults (G0/G1), the FSM state encodings, and the K=3 and R=1/2 constants, shared with the decoder.
REQ-030 SHALL place the encoding step in sub-module conv_enc_step: combinational, {u,s1,s0} -> {out0,out1,next state}; all registers stay in the top.

Verification
REQ-031 SHALL verify: reset, then byte 0x00 with busy_i=0 -> data_o=16'h0000, dvalid_o high exactly 9 cycles after accept.
REQ-032 SHALL verify: reset, then byte 0x80 -> data_o=16'hEC00, final state 00.
REQ-033 SHALL verify: reset, then byte 0xFF -> 16'hDAAA, state 11; next byte 0x00 -> 16'h7000.
REQ-034 SHALL verify: byte 0xFF, then clear_i with byte 0x00 accepted in the same IDLE cycle -> second word 16'h0000.
REQ-035 SHALL verify: busy_i held high 20 cycles after ENC completes -> no pulse and byte_ready_o=0; busy_i low -> one pulse next cycle with correct word.
REQ-036 SHALL verify: rst_n pulsed low at ENC bit 4 -> no dvalid_o, byte_ready_o=1; with VITERBI_ERR_INJECT_EN, byte 0x80 and mask 16'h0001 -> 16'hEC01.
